multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath: an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It drives the PC/IR write enables, ALU operand selects and memory request handshake, and emits the per-instruction regwrite/memread/memwrite/memtoreg strobes. It replaces single-cycle decoding when the datapath shares one memory port and one ALU across cycles.

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/ctrl_outdec.sv | 70 +++++++
 rtl/multicycle_ctrl.sv | 114 +++++++++++
 tb/tb_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer.
// ILLEGAL_TRAP_EN adds the HALT state used to trap unsupported opcodes.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
    ,S_HALT  = 3'd5
`endif
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwrite_cond;
    logic       irwrite;
    logic       mem_req;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
  } ctrl_out_t;

  function automatic logic opc_supported(input logic [6:0] opc);
    return opc inside {OPC_R, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational control-output decode from (state, opcode, mem_ready).
// ILLEGAL_TRAP_EN suppresses the NOP retire pulse for unsupported opcodes.
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [6:0] i_opcode,
  input  logic       i_mem_ready,
  output ctrl_out_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.memread = 1'b1;
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.irwrite = i_mem_ready;
        o_ctrl.pcwrite = i_mem_ready;
      end
      S_DECODE: begin
        // ALU precomputes PC + imm so a branch target sits in ALUOut
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
`ifndef ILLEGAL_TRAP_EN
        o_ctrl.instr_done = !opc_supported(i_opcode);
`endif
      end
      S_EXEC: begin
        o_ctrl.alusrca = 1'b1;
        case (i_opcode)
          OPC_R: begin
            o_ctrl.alusrcb = SRCB_RS2;
            o_ctrl.aluop   = ALUOP_FUNCT;
          end
          OPC_IALU: begin
            o_ctrl.alusrcb = SRCB_IMM;
            o_ctrl.aluop   = ALUOP_FUNCT;
          end
          OPC_LOAD, OPC_STORE: begin
            o_ctrl.alusrcb = SRCB_IMM;
            o_ctrl.aluop   = ALUOP_ADD;
          end
          OPC_BRANCH: begin
            o_ctrl.alusrcb      = SRCB_RS2;
            o_ctrl.aluop        = ALUOP_SUB;
            o_ctrl.pcwrite_cond = 1'b1;
            o_ctrl.instr_done   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        o_ctrl.mem_req    = 1'b1;
        o_ctrl.memread    = (i_opcode == OPC_LOAD);
        o_ctrl.memwrite   = (i_opcode == OPC_STORE);
        o_ctrl.instr_done = i_mem_ready && (i_opcode == OPC_STORE);
      end
      S_WB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
        o_ctrl.memtoreg   = (i_opcode == OPC_LOAD);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: state register, next-state and memory timeout.
// ILLEGAL_TRAP_EN adds the HALT state and the sticky illegal_o flag.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pcwrite_o,
  output logic       pcwrite_cond_o,
  output logic       irwrite_o,
  output logic       mem_req_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       memtoreg_o,
  output logic       regwrite_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] aluop_o,
  output logic       instr_done_o,
  output logic       timeout_o
`ifdef ILLEGAL_TRAP_EN
  ,output logic      illegal_o
`endif
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  ctrl_out_t       w_dec, w_out;
  logic            w_timeout;

  ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_opcode    (opcode_i),
    .i_mem_ready (mem_ready_i),
    .o_ctrl      (w_dec)
  );

  assign w_timeout = (MEM_TIMEOUT != 0) && w_dec.mem_req && !mem_ready_i &&
                     (r_cnt == CW'(MEM_TIMEOUT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready_i) w_next = S_DECODE;
      S_DECODE: begin
        if (opc_supported(opcode_i)) w_next = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        else                         w_next = S_HALT;
`else
        else                         w_next = S_FETCH;
`endif
      end
      S_EXEC: begin
        case (opcode_i)
          OPC_R, OPC_IALU:     w_next = S_WB;
          OPC_LOAD, OPC_STORE: w_next = S_MEM;
          default:             w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready_i)    w_next = (opcode_i == OPC_LOAD) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
  end

  // Counter only runs while a request is stalled; anything else (including
  // the timeout itself) leaves it at zero for the next FETCH/MEM entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_dec.mem_req && !mem_ready_i && !w_timeout) r_cnt <= r_cnt + CW'(1);
      else                                             r_cnt <= '0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  r_illegal <= 1'b0;
    else if (w_next == S_HALT)  r_illegal <= 1'b1;
  end
  assign illegal_o = r_illegal;
`endif

  // Reset forces every strobe low asynchronously, even though state reads FETCH.
  assign w_out = rst_i ? '0 : w_dec;

  assign pcwrite_o      = w_out.pcwrite;
  assign pcwrite_cond_o = w_out.pcwrite_cond;
  assign irwrite_o      = w_out.irwrite;
  assign mem_req_o      = w_out.mem_req;
  assign memread_o      = w_out.memread;
  assign memwrite_o     = w_out.memwrite;
  assign memtoreg_o     = w_out.memtoreg;
  assign regwrite_o     = w_out.regwrite;
  assign alusrca_o      = w_out.alusrca;
  assign alusrcb_o      = w_out.alusrcb;
  assign aluop_o        = w_out.aluop;
  assign instr_done_o   = w_out.instr_done;
  assign timeout_o      = w_timeout && !rst_i;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output
// sequences built from phase rules (fetch/decode/exec/mem/wb, waits, timeout).
module tb_multicycle_ctrl;

  localparam int T = 3;
  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opc;
  logic rdy;
  logic pcwrite_o, pcwrite_cond_o, irwrite_o, mem_req_o, memread_o, memwrite_o;
  logic memtoreg_o, regwrite_o, alusrca_o, instr_done_o, timeout_o;
  logic [1:0] alusrcb_o, aluop_o;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_o;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opc), .mem_ready_i(rdy),
    .pcwrite_o(pcwrite_o), .pcwrite_cond_o(pcwrite_cond_o), .irwrite_o(irwrite_o),
    .mem_req_o(mem_req_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o), .alusrca_o(alusrca_o),
    .alusrcb_o(alusrcb_o), .aluop_o(aluop_o), .instr_done_o(instr_done_o),
    .timeout_o(timeout_o)
`ifdef ILLEGAL_TRAP_EN
    ,.illegal_o(illegal_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, irw, req, rd, wr, m2r, rw, a;
    logic [1:0] b, op;
    logic done, to;
  } vec_t;

  vec_t obs;
  assign obs = {pcwrite_o, pcwrite_cond_o, irwrite_o, mem_req_o, memread_o, memwrite_o,
                memtoreg_o, regwrite_o, alusrca_o, alusrcb_o, aluop_o, instr_done_o, timeout_o};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input vec_t e);
    n_vec++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs sampled 1ns later.
  task automatic cyc(input string tag, input logic r, input logic [6:0] o, input vec_t e);
    @(negedge clk);
    rst = 1'b0; rdy = r; opc = o;
    #1 chk(tag, e);
  endtask

  // w wait cycles; w > T means ready never comes and the request times out.
  task automatic wait_phase(input string tag, input int w, input vec_t base,
                            input logic [6:0] o, output bit ok);
    vec_t e;
    ok = 1'b1;
    if (w > T) begin
      for (int i = 0; i < T; i++) cyc(tag, 1'b0, o, base);
      e = base; e.to = 1'b1;
      cyc({tag, "_timeout"}, 1'b0, o, e);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < w; i++) cyc(tag, 1'b0, o, base);
    end
  endtask

  function automatic bit supported(input logic [6:0] o);
    return (o == R) || (o == IA) || (o == LD) || (o == ST) || (o == BR);
  endfunction

  task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input bit cut = 1'b0);
    vec_t e;
    bit ok;
    logic [6:0] g;
    logic ld, st;
    g  = 7'($urandom);
    ld = (o == LD);
    st = (o == ST);
    e = '0; e.req = 1'b1; e.rd = 1'b1; e.b = 2'b01;
    wait_phase("fetch_wait", fw, e, g, ok);
    if (!ok) return;
    e.irw = 1'b1; e.pcw = 1'b1;
    cyc("fetch_rdy", 1'b1, g, e);
    e = '0; e.b = 2'b10;
`ifndef ILLEGAL_TRAP_EN
    e.done = !supported(o);
`endif
    cyc("decode", 1'($urandom_range(0, 1)), o, e);
    if (!supported(o)) return;
    e = '0; e.a = 1'b1;
    if (o == R)            begin e.b = 2'b00; e.op = 2'b10; end
    else if (o == IA)      begin e.b = 2'b10; e.op = 2'b10; end
    else if (ld || st)     begin e.b = 2'b10; e.op = 2'b00; end
    else begin e.b = 2'b00; e.op = 2'b01; e.pcwc = 1'b1; e.done = 1'b1; end
    cyc("exec", 1'($urandom_range(0, 1)), o, e);
    if (o == BR) return;
    if (ld || st) begin
      e = '0; e.req = 1'b1; e.rd = ld; e.wr = st;
      if (cut) begin
        cyc("mem_wait", 1'b0, o, e);
        return;
      end
      wait_phase("mem_wait", mw, e, o, ok);
      if (!ok) return;
      e.done = st;
      cyc("mem_rdy", 1'b1, o, e);
      if (st) return;
    end
    e = '0; e.rw = 1'b1; e.done = 1'b1; e.m2r = ld;
    cyc("wb", 1'($urandom_range(0, 1)), o, e);
  endtask

  function automatic logic [6:0] pick_opc();
    logic [6:0] o;
    case ($urandom_range(0, 5))
      0: o = R;
      1: o = IA;
      2: o = LD;
      3: o = ST;
      4: o = BR;
      default: begin
        o = 7'($urandom);
        while (supported(o)) o = 7'($urandom);
`ifdef ILLEGAL_TRAP_EN
        o = R;
`endif
      end
    endcase
    return o;
  endfunction

  function automatic int pick_wait();
    int u;
    u = int'($urandom_range(0, 9));
    return (u < 5) ? 0 : (u < 9) ? u - 4 : T + 1;
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; opc = R;
    #2 chk("reset_async", '0);
    @(negedge clk); rdy = 1'b0; #1 chk("reset_hold", '0);
    @(negedge clk); rdy = 1'b1; opc = ST; #1 chk("reset_hold_rdy", '0);

    run_instr(R, 0, 0);
    run_instr(LD, 2, 1);
    run_instr(ST, 0, 2);
    run_instr(BR, 0, 0);
    run_instr(IA, 1, 0);
    run_instr(R, T + 1, 0);
    run_instr(LD, T, T);
    run_instr(ST, 0, T + 1);
    run_instr(LD, 1, T + 1);
`ifndef ILLEGAL_TRAP_EN
    run_instr(7'b1111111, 0, 0);
`endif

    for (int k = 0; k < 150; k++) run_instr(pick_opc(), pick_wait(), pick_wait());

    // Asynchronous reset in the middle of a store's MEM wait.
    run_instr(ST, 0, 0, 1'b1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_mem", '0);
    rdy = 1'b1;
    #1 chk("rst_mid_mem_rdy", '0);
    @(negedge clk); #1 chk("rst_mid_mem_hold", '0);
    run_instr(LD, 0, 0);

`ifdef ILLEGAL_TRAP_EN
    run_instr(7'b1111111, 0, 0);
    n_vec++;
    assert (illegal_o === 1'b0) else begin
      n_bad++; $error("FAIL illegal_early: observed %b expected 0", illegal_o);
    end
    for (int k = 0; k < 4; k++) begin
      cyc("halt", 1'($urandom_range(0, 1)), R, '0);
      n_vec++;
      assert (illegal_o === 1'b1) else begin
        n_bad++; $error("FAIL illegal_sticky: observed %b expected 1", illegal_o);
      end
    end
    @(negedge clk); rst = 1'b1;
    #1 chk("halt_reset", '0);
    n_vec++;
    assert (illegal_o === 1'b0) else begin
      n_bad++; $error("FAIL illegal_reset: observed %b expected 0", illegal_o);
    end
    run_instr(BR, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
